// File: rtl/mems_spi_tx.sv
// SPI serializer for the quad DAC: accepts one command word per start pulse and
// shifts it MSB-first on sclk/mosi/sync_n, holding busy through the inter-frame gap.
module mems_spi_tx #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  sync_n
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam int unsigned DIV_W = 8;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] GAP_RELOAD = DIV_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      GAP
   } state_t;

   state_t                state;
   // The MSB goes straight to mosi at accept time, so only the remaining bits are held.
   logic [DATA_WIDTH-2:0] shift_reg;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DIV_W-1:0]      div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sclk      <= 1'b1;
         mosi      <= 1'b0;
         sync_n    <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= data_in[DATA_WIDTH-2:0];
                  mosi      <= data_in[DATA_WIDTH-1];
                  busy      <= 1'b1;
                  sync_n    <= 1'b0;
                  sclk      <= 1'b1;
                  bit_cnt   <= '0;
                  div_cnt   <= DIV_RELOAD;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (div_cnt == '0) begin
                  sclk    <= 1'b0;
                  div_cnt <= DIV_RELOAD;
                  state   <= SHIFT_LO;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            SHIFT_LO: begin
               if (div_cnt == '0) begin
                  sclk <= 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     sync_n  <= 1'b1;
                     mosi    <= 1'b0;
                     div_cnt <= GAP_RELOAD;
                     state   <= GAP;
                  end else begin
                     // Data only moves on the rising edge, away from the DAC's sampling edge.
                     mosi      <= shift_reg[DATA_WIDTH-2];
                     shift_reg <= {shift_reg[DATA_WIDTH-3:0], 1'b0};
                     bit_cnt   <= bit_cnt + CNT_W'(1);
                     div_cnt   <= DIV_RELOAD;
                     state     <= SHIFT_HI;
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            SHIFT_HI: begin
               if (div_cnt == '0) begin
                  sclk    <= 1'b0;
                  div_cnt <= DIV_RELOAD;
                  state   <= SHIFT_LO;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            GAP: begin
               if (div_cnt == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mems_spi_tx.sv
// Directed bench for mems_spi_tx: a negedge monitor rebuilds each frame from the
// pins and the main sequence checks timing, content and handshake behaviour.
module tb_mems_spi_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] data_in = '0;
   logic        busy, done, sclk, mosi, sync_n;

   int tests = 0;
   int fails = 0;

   // monitor state
   logic        prev_sclk = 1'b1;
   logic        prev_sync = 1'b1;
   logic [23:0] cur_word = '0;
   int          cur_nfall = 0;
   logic [23:0] last_word = '0;
   int          last_nfall = 0;
   int          frame_cnt = 0;
   int          sclk_edges = 0;
   int          done_cnt = 0;
   int          busy_drops = 0;
   int          high_cnt = 0;
   int          last_gap = 0;

   logic [23:0] ctl_words [5] = '{24'h300123, 24'h310456, 24'h330789, 24'h340ABC, 24'h350DEF};

   mems_spi_tx dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .sclk    (sclk),
      .mosi    (mosi),
      .sync_n  (sync_n)
   );

   always #5 clk = ~clk;

   // Pin-level frame reconstruction, sampled mid-cycle.
   always @(negedge clk) begin
      if (sclk !== prev_sclk) sclk_edges++;
      if (done === 1'b1) done_cnt++;
      if (sync_n === 1'b0 && busy !== 1'b1) busy_drops++;
      if (prev_sync === 1'b1 && sync_n === 1'b0) begin
         last_gap  = high_cnt;
         cur_word  = '0;
         cur_nfall = 0;
      end
      if (sync_n === 1'b1) high_cnt++;
      else high_cnt = 0;
      if (prev_sclk === 1'b1 && sclk === 1'b0 && sync_n === 1'b0) begin
         cur_word = {cur_word[22:0], mosi};
         cur_nfall++;
      end
      if (prev_sync === 1'b0 && sync_n === 1'b1) begin
         last_word  = cur_word;
         last_nfall = cur_nfall;
         frame_cnt++;
      end
      prev_sclk = sclk;
      prev_sync = sync_n;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      check(tag, 32'(done), 1);
   endtask

   task automatic send(input logic [23:0] w);
      data_in = w;
      start   = 1'b1;
      tick(1);
      start   = 1'b0;
   endtask

   initial begin
      int f0, d0, n;

      // Reset state and quiet sclk
      tick(3);
      check("rst_sclk", 32'(sclk), 1);
      check("rst_sync", 32'(sync_n), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_mosi", 32'(mosi), 0);
      rst_n = 1'b1;
      tick(1);
      sclk_edges = 0;
      tick(50);
      check("idle_sclk_edges", 32'(sclk_edges), 0);
      check("idle_busy", 32'(busy), 0);

      // Single frame with start pulses dropped while busy
      f0 = frame_cnt;
      send(24'h3F00A5);
      check("t1_busy", 32'(busy), 1);
      check("t1_sync", 32'(sync_n), 0);
      check("t1_mosi_msb", 32'(mosi), 0);
      check("t1_sclk", 32'(sclk), 1);
      tick(8);
      data_in = 24'hFFFFFF;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(39);
      data_in = 24'h123456;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(50);
      check("t100_busy", 32'(busy), 1);
      check("t100_done", 32'(done), 0);
      tick(1);
      check("t101_busy", 32'(busy), 0);
      check("t101_done", 32'(done), 1);
      tick(1);
      check("t102_done", 32'(done), 0);
      check("single_word", 32'(last_word), 32'h3F00A5);
      check("single_nfall", 32'(last_nfall), 24);
      check("single_frames", 32'(frame_cnt - f0), 1);
      tick(10);
      check("no_queued_frame", 32'(busy), 0);

      // Back-to-back: restart in the done cycle
      send(24'hC35A96);
      wait_done("b2b_a_done");
      data_in = 24'h5A0FF0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 1);
      check("b2b_sync", 32'(sync_n), 0);
      check("b2b_a_word", 32'(last_word), 32'hC35A96);
      wait_done("b2b_b_done");
      check("b2b_b_word", 32'(last_word), 32'h5A0FF0);
      check("b2b_gap_ge4", 32'(last_gap >= 4), 1);
      tick(3);

      // Controller-style sequence: addr 0,1,3,4,5
      f0 = frame_cnt;
      busy_drops = 0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (busy !== 1'b0 && n < 400) begin
            tick(1);
            n++;
         end
         send(ctl_words[k]);
         data_in = ~ctl_words[k];
         wait_done("ctl_done");
         check("ctl_word", 32'(last_word), 32'(ctl_words[k]));
         check("ctl_nfall", 32'(last_nfall), 24);
      end
      check("ctl_frames", 32'(frame_cnt - f0), 5);
      check("ctl_busy_drops", 32'(busy_drops), 0);
      tick(3);

      // Mid-frame reset after the 10th falling edge
      send(24'hABCDEF);
      n = 0;
      while (cur_nfall < 10 && n < 400) begin
         tick(1);
         n++;
      end
      check("mid_reached_10", 32'(cur_nfall >= 10), 1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("mid_sclk", 32'(sclk), 1);
      check("mid_sync", 32'(sync_n), 1);
      check("mid_busy", 32'(busy), 0);
      check("mid_done", 32'(done), 0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check("mid_no_done", 32'(done_cnt - d0), 0);
      f0 = frame_cnt;
      send(24'h96C3E1);
      wait_done("post_rst_done");
      check("post_rst_word", 32'(last_word), 32'h96C3E1);
      check("post_rst_nfall", 32'(last_nfall), 24);
      check("post_rst_frames", 32'(frame_cnt - f0), 1);
      tick(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mems_spi_tx.md
Name: mems_spi_tx

Overview:
- SPI serializer that is the responder on the mems_SPI_start / data / mems_SPI_busy handshake issued by the MEMS scan controller.
- Accepts one 24-bit DAC command word per start pulse and shifts it MSB-first to the quad DAC over SCLK/MOSI/SYNC_n.
- Holds busy until the frame, including the inter-frame SYNC_n-high gap, is complete.
- Sits between the MEMS scan controller and the DAC pins.

Parameters:
- DATA_WIDTH, 24, bits per DAC frame.
- CLK_DIV, 2, system clocks per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 4, system clocks SYNC_n is held high after a frame before busy drops; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; connects to mems_SPI_start.
- data_in  input  DATA_WIDTH  command word; connects to the controller's data_miso; sampled only on an accepted start.
- busy  output  1  registered; connects to mems_SPI_busy.
- done  output  1  one-cycle pulse when busy falls.
- sclk  output  1  SPI clock; idles high.
- mosi  output  1  serial data, MSB first.
- sync_n  output  1  DAC frame sync; active low.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE; busy=0, done=0, sclk=1, sync_n=1, mosi=0.
  - Shift register and counters cleared; any partial frame is abandoned with no done pulse.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP.
- IDLE:
  - start=1 in cycle T is accepted: latch data_in into shift_reg.
  - At cycle T+1: busy=1, sync_n=0, mosi=data_in[DATA_WIDTH-1], sclk=1; bit_cnt=0; enter SETUP.
  - start is ignored whenever busy=1. No queuing; a start arriving while busy is dropped.
- SETUP: hold for CLK_DIV cycles, then sclk falls (DAC samples the MSB); enter SHIFT_LO.
- SHIFT_LO:
  - Hold for CLK_DIV cycles, then sclk rises.
  - If bit_cnt=DATA_WIDTH-1: in the same cycle sync_n=1 and mosi=0; enter GAP.
  - Otherwise: in the same cycle shift left, mosi=next bit, bit_cnt+1; enter SHIFT_HI.
- SHIFT_HI: hold for CLK_DIV cycles, then sclk falls; enter SHIFT_LO.
- Edge timing:
  - Exactly DATA_WIDTH falling edges occur per frame with sync_n low.
  - mosi changes only on sclk rising edges, so it is stable for CLK_DIV cycles either side of each falling edge.
- GAP:
  - Hold for GAP_CYCLES cycles with sync_n=1 and sclk=1.
  - Then busy=0 and done=1 for one cycle; enter IDLE.
- Latency: accepted start at cycle T gives busy high from T+1 through T+48·CLK_DIV+GAP_CYCLES inclusive; busy low at T+1+48·CLK_DIV+GAP_CYCLES (DATA_WIDTH=24).
- Handshake compatibility:
  - busy is asserted in the first cycle after the start pulse, so a controller that tests !busy while its own start is low never double-issues.
  - In the done cycle, state=IDLE and busy=0, so a start in that same cycle is accepted.
- Counters:
  - Divider counter is 8 bits and reloads at CLK_DIV-1.
  - bit_cnt is clog2(DATA_WIDTH) bits.
  - No wrap beyond DATA_WIDTH-1 is possible.
- data_in changes while busy have no effect on the frame in flight.

Test Plan:
- Reset state: hold rst_n=0, then release -> sclk=1, sync_n=1, busy=0, done=0, mosi=0; no edges on sclk for 50 cycles.
- Single frame (CLK_DIV=2, GAP_CYCLES=4): start with data_in=0x3F_00A5 at cycle 10. Required:
  - busy=1 at cycle 11 and busy=0 with done=1 at cycle 111.
  - Exactly 24 sclk falling edges while sync_n=0; bits captured on falls read 0x3F00A5.
- Busy protection: pulse start again at cycles 20 and 60 during the frame -> ignored; only one frame emitted and data unchanged.
- Back-to-back: assert start in the done cycle -> next frame begins with sync_n low one cycle later; gap of ≥4 cycles with sync_n high observed between frames.
- Controller sequence: connect the scan controller and fire mems_soft_reset -> five frames emitted in order for addr 0, 1, 3, 4, 5; busy never drops inside a frame.
- Mid-frame reset: drop rst_n after the 10th falling edge -> immediately sclk=1, sync_n=1, busy=0, no done pulse; a fresh start afterwards yields a complete 24-bit frame.
